// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared defaults and mode encodings for the serial pattern detector
package seq_detect_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam logic [3:0] PATTERN_DEF = 4'b1011;
  localparam int         CNT_W_DEF   = 8;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;

  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } overlap_e;

  typedef enum logic {
    DET_MEALY = 1'b0,
    DET_MOORE = 1'b1
  } detect_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with a synchronous clear that beats increment
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with match counter
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter bit               OVERLAP = bit'(OVL_ON),
  parameter bit               MOORE   = bit'(DET_MEALY),
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

  generate
    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
      $error("seq_detect_param: PAT_W must be within 2..16");
    end
  endgenerate

  logic [PAT_W-2:0]  hist_q;
  logic [PAT_W-2:0]  hist_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic [PAT_W-1:0]  window;
  logic              hit;

  // rst gates the hit so the Mealy output is low throughout reset
  always_comb begin
    window = {hist_q, din};
    hit    = rst && en && (fill_q == FILL_FULL) && (window == PATTERN);
    hist_d = hist_q;
    fill_d = fill_q;
    if (en) begin
      hist_d = window[PAT_W-2:0];
      if (hit && !OVERLAP) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  generate
    if (MOORE) begin : g_moore
      logic y_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          y_q <= 1'b0;
        end else begin
          y_q <= hit;
        end
      end
      assign y = y_q;
    end else begin : g_mealy
      assign y = hit;
    end
  endgenerate

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .inc(hit),
    .q  (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed vector bench for seq_detect_param across four configurations
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       din = 1'b0;
  logic       clr = 1'b0;
  logic       y_a, y_b, y_m, y_c;
  logic [7:0] cnt_a, cnt_b, cnt_m;
  logic [1:0] cnt_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_param u_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .y(y_a), .match_cnt(cnt_a)
  );
  seq_detect_param #(.OVERLAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .y(y_b), .match_cnt(cnt_b)
  );
  seq_detect_param #(.MOORE(1'b1)) u_m (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .y(y_m), .match_cnt(cnt_m)
  );
  seq_detect_param #(.CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr), .y(y_c), .match_cnt(cnt_c)
  );

  typedef struct {
    logic       en;
    logic       din;
    logic       clr;
    logic       y_a;
    logic [7:0] cnt_a;
    logic       y_b;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic bit_in(input logic d);
    en = 1'b1; din = d; clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_dut;
    en = 1'b0; din = 1'b0; clr = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // {en, din, clr, y_a, cnt_a, y_b(no overlap), cnt_b, cnt_c(2-bit)}; counts are after the edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 2'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 1'b1, 8'd1, 2'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 2'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 2'd1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 2'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 2'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0, 8'd1, 2'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1, 8'd2, 2'd2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0, 8'd2, 2'd2};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0, 8'd2, 2'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd2, 2'd3};

    // reset state, with bus activity that must not leak through
    en = 1'b1; din = 1'b1;
    #1;
    chk("rst_y_a", {7'd0, y_a}, 8'd0);
    chk("rst_y_m", {7'd0, y_m}, 8'd0);
    chk("rst_cnt_a", cnt_a, 8'd0);
    chk("rst_cnt_c", {6'd0, cnt_c}, 8'd0);
    reset_dut();

    // main stream, overlapping vs non-overlapping, Mealy vs Moore
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; din = tbl[i].din; clr = tbl[i].clr;
      #3;
      chk($sformatf("tbl%0d_y_a", i + 1), {7'd0, y_a}, {7'd0, tbl[i].y_a});
      chk($sformatf("tbl%0d_y_b", i + 1), {7'd0, y_b}, {7'd0, tbl[i].y_b});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_cnt_a", i + 1), cnt_a, tbl[i].cnt_a);
      chk($sformatf("tbl%0d_cnt_b", i + 1), cnt_b, tbl[i].cnt_b);
      chk($sformatf("tbl%0d_cnt_c", i + 1), {6'd0, cnt_c}, {6'd0, tbl[i].cnt_c});
      chk($sformatf("tbl%0d_y_m", i + 1), {7'd0, y_m}, {7'd0, tbl[i].y_a});
    end

    // Moore pulse lasts exactly one cycle after the completing bit
    reset_dut();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    en = 1'b1; din = 1'b1;
    #3;
    chk("moore_not_comb", {7'd0, y_m}, 8'd0);
    chk("mealy_comb", {7'd0, y_a}, 8'd1);
    @(posedge clk); #1;
    chk("moore_pulse", {7'd0, y_m}, 8'd1);
    en = 1'b0;
    @(posedge clk); #1;
    chk("moore_one_cycle", {7'd0, y_m}, 8'd0);

    // second overlapping hit, then asynchronous reset mid-cycle
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("moore_second", {7'd0, y_m}, 8'd1);
    chk("cnt_before_rst", cnt_a, 8'd2);
    en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("async_y_m", {7'd0, y_m}, 8'd0);
    chk("async_cnt_a", cnt_a, 8'd0);
    chk("async_cnt_m", cnt_m, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // partial 101 then reset: the final 1 must not complete a match
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("rst_mid_y_a", {7'd0, y_a}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    en = 1'b1; din = 1'b1;
    #3;
    chk("after_rst_no_hit", {7'd0, y_a}, 8'd0);
    @(posedge clk); #1;
    chk("after_rst_cnt", cnt_a, 8'd0);

    // en gap holds history and suppresses y
    reset_dut();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    for (int k = 0; k < 3; k++) begin
      en = 1'b0; din = 1'b1;
      #3;
      chk($sformatf("gap%0d_y_a", k), {7'd0, y_a}, 8'd0);
      @(posedge clk); #1;
    end
    en = 1'b1; din = 1'b1;
    #3;
    chk("gap_final_hit", {7'd0, y_a}, 8'd1);
    @(posedge clk); #1;
    chk("gap_cnt", cnt_a, 8'd1);

    // five overlapping hits saturate the 2-bit counter, then clr beats a hit
    reset_dut();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    for (int k = 0; k < 4; k++) begin
      bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    end
    chk("sat_cnt_c", {6'd0, cnt_c}, 8'd3);
    chk("sat_cnt_a", cnt_a, 8'd5);
    bit_in(1'b0); bit_in(1'b1);
    en = 1'b1; din = 1'b1; clr = 1'b1;
    #3;
    chk("clr_keeps_y", {7'd0, y_a}, 8'd1);
    @(posedge clk); #1;
    chk("clr_cnt_c", {6'd0, cnt_c}, 8'd0);
    chk("clr_cnt_a", cnt_a, 8'd0);
    chk("clr_keeps_moore", {7'd0, y_m}, 8'd1);
    en = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("post_clr_detect", cnt_a, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning the pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011, meaning the target sequence; PATTERN[PAT_W-1] is the first bit received.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping detection and 0 = non-overlapping detection.
REQ-004 The block SHALL have parameter MOORE, default 0, meaning 0 = Mealy (combinational) detect and 1 = registered detect.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning the match-counter width.
REQ-006 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, width 1, meaning reset; asynchronous and active-low.
REQ-008 The block SHALL have port en, input, width 1, meaning din is a valid serial bit this cycle.
REQ-009 The block SHALL have port din, input, width 1, meaning the serial data bit.
REQ-010 The block SHALL have port clr, input, width 1, meaning synchronous clear of match_cnt.
REQ-011 The block SHALL have port y, output, width 1, meaning the detect pulse.
REQ-012 The block SHALL have port match_cnt, output, width CNT_W, meaning the number of detections since reset or clr.

Function
REQ-013 The block SHALL hold a PAT_W-1 bit history register that shifts din in at the LSB on each cycle with en=1, and holds otherwise.
REQ-014 The block SHALL keep a fill count (0..PAT_W-1, saturating) of valid history bits; it increments on en=1 when not saturated.
REQ-015 A hit SHALL occur when en=1, fill = PAT_W-1, and {history, din} equals PATTERN.
REQ-016 When MOORE=0, y SHALL equal the hit combinationally in the same cycle as the completing bit.
REQ-017 When MOORE=1, y SHALL be a register loaded with the hit, high for exactly one cycle after the completing bit; en=0 loads 0.
REQ-018 When OVERLAP=1, a hit SHALL leave history and fill updated normally, so suffix bits may begin the next match.
REQ-019 When OVERLAP=0, a hit SHALL set fill to 0 on that edge, so the next match needs PAT_W fresh bits.
REQ-020 With en=0, y SHALL be 0 in Mealy mode, and history, fill and match_cnt SHALL hold.
REQ-021 match_cnt SHALL increment by 1 on each hit and saturate at 2^CNT_W-1 with no wrap.
REQ-022 clr=1 SHALL set match_cnt to 0 on the next edge; clr takes priority over a simultaneous hit.
REQ-023 clr SHALL NOT affect history, fill or y, so detection continues uninterrupted.

Reset
REQ-024 Assertion of rst=0 SHALL immediately force history=0, fill=0, match_cnt=0, and the Moore y register to 0, independent of clk.
REQ-025 A reset mid-pattern SHALL discard partial progress, so the first hit after release requires PAT_W new valid bits.
REQ-026 Mealy y SHALL be 0 whenever rst=0.

Structure
REQ-027 The default PAT_W, PATTERN, CNT_W and the mode encodings (OVERLAP/MOORE values) SHALL live in a shared package, seq_detect_pkg.
REQ-028 The saturating match counter with priority clear SHALL be a sub-module, sat_counter (parameter CNT_W; ports clk, rst, clr, inc, q).
REQ-029 An elaboration check SHALL reject PAT_W < 2 or PAT_W > 16.

Verification
REQ-030 Defaults with en=1 and stream 0,1,0,1,1,0,0,1,0,1,1,0,1,1 -> y high on bits 5, 11 and 14 (1-based); match_cnt=3.
REQ-031 Same stream with OVERLAP=0 -> y high on bits 5 and 11 only; match_cnt=2.
REQ-032 MOORE=1 with stream 1,0,1,1 -> y high for exactly one cycle, on the edge after bit 4.
REQ-033 Stream 1,0,1 then en=0 for 3 cycles then 1 -> a single hit on the final bit; y=0 during the en=0 gap.
REQ-034 CNT_W=2 with 5 overlapping hits -> match_cnt=3 held; clr asserted on a hit cycle -> match_cnt=0.
REQ-035 Stream 1,0,1, then rst pulsed low mid-cycle, then 1 -> no hit; outputs are 0 immediately on assertion.
